// File: rtl/mult_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier serving MUL / UMULH / SMULH.
// Fixed latency: accept, WIDTH iterations, one sign-fix cycle, one done cycle.
module mult_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic [1:0]       mult_mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             multiplier_done,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     addend, sum;
  logic [2*WIDTH-1:0] fixed;
  logic               high_half;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is correct unsigned.
  assign abs_a     = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign abs_b     = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign addend    = {1'b0, mcand_q} & {(WIDTH+1){mplier_q[0]}};
  assign sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + addend;
  assign fixed     = neg_q ? -prod_q : prod_q;
  assign high_half = (mode_q == 2'b01) || (mode_q == 2'b10);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mult_start) begin
          mode_d  = mult_mode;
          neg_d   = (mult_mode == 2'b10) && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
          if (mult_mode == 2'b10) begin
            mcand_d  = abs_a;
            mplier_d = abs_b;
          end else begin
            mcand_d  = operand_a;
            mplier_d = operand_b;
          end
          prod_d  = '0;
          cnt_d   = CW'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Carry-out of the add becomes the new MSB after the right shift.
        prod_d   = {sum, prod_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        prod_d   = fixed;
        result_d = high_half ? fixed[2*WIDTH-1:WIDTH] : fixed[WIDTH-1:0];
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign multiplier_done = done_q;
  assign result          = result_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: vector table, random vectors against a
// full-width product model, and hand-written latency / hold / back-to-back / reset sequences.
module tb_mult_sequencer;

  localparam int W   = 64;
  localparam int LAT = W + 2;

  logic         clk;
  logic         reset;
  logic         mult_start;
  logic [1:0]   mult_mode;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         multiplier_done;
  logic [W-1:0] result;
  logic         busy;

  int checks;
  int errors;
  int cyc;
  logic [W-1:0] sb[$];

  mult_sequencer #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .mult_start      (mult_start),
    .mult_mode       (mult_mode),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .multiplier_done (multiplier_done),
    .result          (result),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    if (m == 2'b10) p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    else            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return ((m == 2'b01) || (m == 2'b10)) ? p[2*W-1:W] : p[W-1:0];
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && multiplier_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 result=%h expected no done (t=%0t)", result, $time);
      end else begin
        e = sb.pop_front();
        chk("result", result, e);
      end
    end
  end

  // Issues one operation and waits (bounded) for its done pulse. With hold set,
  // start stays high and operands/mode are scrambled every cycle until done.
  task automatic do_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input bit hold, output int dcyc);
    int c0;
    bit seen;
    @(negedge clk);
    mult_mode  = m;
    operand_a  = a;
    operand_b  = b;
    mult_start = 1'b1;
    sb.push_back(exp);
    c0   = cyc;
    seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 4 * LAT && !seen; i++) begin
      @(negedge clk);
      if (hold) begin
        operand_a = {$urandom(), $urandom()};
        operand_b = {$urandom(), $urandom()};
        mult_mode = 2'($urandom_range(0, 3));
      end else begin
        mult_start = 1'b0;
      end
      if (i == 0) chk("busy_after_accept", W'(busy), W'(1));
      if (multiplier_done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    mult_start = 1'b0;
    chk("done_seen", W'(seen), W'(1));
    if (seen) begin
      chk("latency", W'(dcyc - c0), W'(LAT));
      chk("busy_in_done", W'(busy), W'(0));
    end else begin
      sb.delete();
    end
  endtask

  vec_t tbl[12];

  initial begin
    int dc1, dc2, c0;
    logic [1:0]   rm;
    logic [W-1:0] ra, rb;

    checks = 0;
    errors = 0;

    tbl[0]  = '{"umulh_ones",   2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[1]  = '{"mul_ones",     2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
    tbl[2]  = '{"smulh_m1x1",   2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[3]  = '{"smulh_min2",   2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    tbl[4]  = '{"mul_m7x3",     2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFEB};
    tbl[5]  = '{"smulh_m7x3",   2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[6]  = '{"umulh_m7x3",   2'b01, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002};
    tbl[7]  = '{"smulh_minx1",  2'b10, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[8]  = '{"smulh_minmax", 2'b10, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'hC000_0000_0000_0000};
    tbl[9]  = '{"mul_zero",     2'b00, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_0000};
    tbl[10] = '{"umulh_2p32",   2'b01, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001};
    tbl[11] = '{"mode11_ones",  2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};

    reset      = 1'b1;
    mult_start = 1'b0;
    mult_mode  = 2'b00;
    operand_a  = '0;
    operand_b  = '0;
    repeat (3) @(negedge clk);
    chk("reset_done",   W'(multiplier_done), W'(0));
    chk("reset_busy",   W'(busy),            W'(0));
    chk("reset_result", result,              '0);
    reset = 1'b0;

    // MUL 3*5, then the result must hold through idle cycles
    do_op(2'b00, 64'd3, 64'd5, 64'd15, 1'b0, dc1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("result_hold", result, 64'd15);
    end

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0, dc1);
    end

    for (int i = 0; i < 8; i++) begin
      rm = 2'($urandom_range(0, 3));
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      do_op(rm, ra, rb, model(rm, ra, rb), 1'b0, dc1);
    end

    // Start held with changing operands: original operands win, latency unchanged
    do_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFA, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, dc1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_after_hold_busy", W'(busy), W'(0));
    end

    // Back-to-back: second start in the cycle right after done
    do_op(2'b00, 64'd9, 64'd11, 64'd99, 1'b0, dc1);
    do_op(2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, dc2);
    chk("b2b_spacing", W'(dc2 - dc1), W'(LAT + 1));

    // Reset during RUN iteration 30
    @(negedge clk);
    mult_mode  = 2'b01;
    operand_a  = 64'h1234_5678_9ABC_DEF0;
    operand_b  = 64'hFEDC_BA98_7654_3210;
    mult_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    mult_start = 1'b0;
    while (cyc < c0 + 30) @(negedge clk);
    chk("busy_before_reset", W'(busy), W'(1));
    chk("result_before_reset", result, 64'hFFFF_FFFF_FFFF_FFEB);
    reset = 1'b1;
    #1;
    chk("async_reset_done",   W'(multiplier_done), W'(0));
    chk("async_reset_busy",   W'(busy),            W'(0));
    chk("async_reset_result", result,              '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", W'(multiplier_done), W'(0));
    end
    do_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, dc1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", W'(sb.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
